// File: rtl/sa_row_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sa_row_feed_scheduler
// Description : Drives the per-row input FIFOs of a systolic array. Row r is
//               read one cycle later than row r-1, so the data arrives with a
//               diagonal skew. When any active row's FIFO is empty, every row
//               stalls together, which keeps the skew intact.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_row_feed_scheduler #(
    parameter int ROW   = 9,
    parameter int DW    = 9,
    parameter int LEN_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_tile_len,
    input  logic [ROW-1:0]      i_fifo_empty,
    input  logic [ROW*DW-1:0]   i_data,
    output logic [ROW-1:0]      o_read_enable,
    output logic [ROW*DW-1:0]   o_data,
    output logic [ROW-1:0]      o_valid,
    output logic                o_busy,
    output logic                o_done
);

    // The step counter must hold L+ROW-1 without wrapping.
    localparam int TW = LEN_W + $clog2(ROW) + 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_feed  = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    logic [1:0]       r_state;
    logic [TW-1:0]    r_t;
    logic [LEN_W-1:0] r_len;
    logic [ROW-1:0]   r_valid;

    logic [ROW-1:0]   w_active;
    logic             w_in_feed;
    logic             w_stall;
    logic [TW-1:0]    w_len_ext;
    logic [TW-1:0]    w_last_step;

    assign w_in_feed   = (r_state == c_feed);
    assign w_len_ext   = TW'(r_len);
    // Final step of a tile is L+ROW-2; L is never 0 inside FEED, so no underflow.
    assign w_last_step = w_len_ext + TW'(ROW) - TW'(2);

    // Row r is active for steps r .. r+L-1.
    for (genvar r = 0; r < ROW; r++) begin : g_row
        assign w_active[r] = (r_t >= TW'(r)) && (r_t < (TW'(r) + w_len_ext));
        assign o_data[r*DW +: DW] = r_valid[r] ? i_data[r*DW +: DW] : '0;
    end

    // Only active rows can stall the feed; idle rows' empty flags are don't-care.
    assign w_stall       = w_in_feed && (|(w_active & i_fifo_empty));
    assign o_read_enable = (w_in_feed && !w_stall) ? w_active : '0;
    assign o_valid       = r_valid;
    assign o_busy        = w_in_feed || (r_state == c_drain);
    assign o_done        = (r_state == c_done);

    // Tile sequencing: length capture, step counting and state transitions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_idle;
            r_t     <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (i_start) begin
                        if (i_tile_len != '0) begin
                            r_len   <= i_tile_len;
                            r_t     <= '0;
                            r_state <= c_feed;
                        end else begin
                            r_state <= c_done;
                        end
                    end
                end
                c_feed: begin
                    if (!w_stall) begin
                        r_t <= r_t + TW'(1);
                        if (r_t == w_last_step) begin
                            r_state <= c_drain;
                        end
                    end
                end
                c_drain: r_state <= c_done;
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Valid follows the read strobe by one cycle to match FIFO read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= o_read_enable;
        end
    end

endmodule
`default_nettype wire

// File: doc/sa_row_feed_scheduler.md
SA_ROW_FEED_SCHEDULER -- requirements
Module: sa_row_feed_scheduler

Interface
- REQ-001 Parameter ROW, default 9, is the number of systolic-array rows, one input FIFO per row.
- REQ-002 Parameter DW, default 9, is the data width per row.
- REQ-003 Parameter LEN_W, default 8, is the width of the tile-length field.
- REQ-004 i_clk, input, 1 bit, is the single clock; all logic is on its rising edge.
- REQ-005 i_rst, input, 1 bit, is the synchronous, active-high reset.
- REQ-006 i_start, input, 1 bit, is a tile start request, sampled only in IDLE.
- REQ-007 i_tile_len, input, LEN_W bits, is the number of elements per row in the tile, sampled with i_start.
- REQ-008 i_fifo_empty, input, ROW bits, is the per-row FIFO empty flag.
- REQ-009 i_data, input, ROW*DW bits, is the per-row FIFO read data; row r occupies [r*DW +: DW] and is valid one cycle after its read enable.
- REQ-010 o_read_enable, output, ROW bits, is the per-row FIFO read strobe.
- REQ-011 o_data, output, ROW*DW bits, is i_data with each row slice forced to 0 when that row's o_valid is 0.
- REQ-012 o_valid, output, ROW bits, marks the per-row data valid toward the array.
- REQ-013 o_busy, output, 1 bit, is high while in FEED or DRAIN.
- REQ-014 o_done, output, 1 bit, is a one-cycle tile-complete pulse.

Function
- REQ-015 The FSM SHALL have exactly four states: IDLE, FEED, DRAIN, DONE.
- REQ-016 IDLE: i_start=1 with i_tile_len!=0 SHALL latch the length L, clear step counter t to 0, and go to FEED.
- REQ-017 IDLE: i_start=1 with i_tile_len=0 SHALL go to DONE with no FIFO reads.
- REQ-018 Row r SHALL be active at step t iff r <= t < r+L; this gives a diagonal skew of one cycle per row.
- REQ-019 stall SHALL be 1 in FEED iff any active row has i_fifo_empty=1; empty flags of inactive rows SHALL be ignored.
- REQ-020 o_read_enable[r] SHALL be combinational: 1 iff state=FEED, row r is active, and stall=0.
- REQ-021 During stall, all rows SHALL hold, t SHALL hold, and no read enables SHALL assert, so the skew is preserved.
- REQ-022 t SHALL increment by 1 on each non-stalled FEED cycle.
- REQ-023 t SHALL be at least LEN_W + clog2(ROW) + 1 bits wide; there is no wrap within a tile.
- REQ-024 A non-stalled FEED cycle with t = L+ROW-2 SHALL move the FSM to DRAIN.
- REQ-025 DRAIN SHALL last exactly 1 cycle and then move to DONE.
- REQ-026 DONE SHALL last exactly 1 cycle with o_done=1 and then return to IDLE.
- REQ-027 o_valid SHALL be o_read_enable registered by one cycle, so it aligns with the FIFO read latency.
- REQ-028 Each row SHALL see exactly L read enables per tile.
- REQ-029 i_start SHALL be ignored outside IDLE.
- REQ-030 i_tile_len changes after the start cycle SHALL have no effect on the tile in progress.
- REQ-031 A new tile SHALL be accepted no earlier than the IDLE cycle that follows DONE.

Reset
- REQ-032 i_rst=1 SHALL force IDLE, t=0, and o_valid=0 at the next edge; o_read_enable, o_busy, o_done and o_data SHALL then be 0.
- REQ-033 Reset SHALL take priority over i_start and over any state, including mid-FEED; no partial tile resumes after reset.

Verification
- REQ-034 ROW=3, L=4, FIFOs never empty, start at cycle 0:
  - FEED occupies cycles 1..6.
  - Row 0 reads in cycles 1-4, row 1 in cycles 2-5, row 2 in cycles 3-6.
  - o_valid is the same pattern one cycle later.
  - DRAIN is cycle 7; o_done is high in cycle 8 only.
- REQ-035 Same setup with row 1 empty at step t=2:
  - All read enables are 0 for that cycle and t holds.
  - Row 1 still reads exactly 4 times.
  - o_done arrives in cycle 9.
- REQ-036 Same setup with row 2 empty during steps 0-1, while row 2 is inactive: no stall, timing identical to REQ-034.
- REQ-037 i_start=1 with i_tile_len=0: zero reads and o_valid never asserts; o_done is high in the next cycle; o_busy stays 0.
- REQ-038 i_rst asserted at FEED step t=3: next cycle all outputs are 0 and the FSM is in IDLE; a new start with L=2 completes normally with 2 reads per row.
- REQ-039 i_start pulsed during FEED with i_tile_len=7: ignored; the running tile keeps L=4 and no second tile starts.
